sprite_line_renderer: RTL
=========================

# sprite_line_renderer

Downstream consumer of the 48-bit render queue and the 24-bit sprite image memory. Once per frame it drains render entries into an internal sprite table. Once per scanline it composites every sprite intersecting that line into a double-buffered 24-bit line buffer, which the VGA scan-out reads. Painter's order applies: later table entries overwrite earlier ones.

## Interface
- `LINE_W`, 640: visible pixels per line.
- `SPRITE_W`, 32: sprite width in pixels.
- `SPRITE_H`, 32: sprite height in lines.
- `MAX_SPRITES`, 25: sprite table depth (1200-bit queue / 48).
- `ADDR_W`, 20: image memory address width.
- `BG_COLOR`, 24'h000000: clear colour.
- `clk50` in 1: system clock. One clock domain only.
- `reset` in 1: asynchronous, active-high.
- `frame_start` in 1: one-cycle pulse at the start of vertical blank.
- `line_req` in 1: one-cycle pulse requesting a render of line `line_y`.
- `line_y` in 10: line to render, sampled with `line_req`.
- `render_q_lw` in 1: queue below low watermark. 1 means no complete entry is available.
- `render_q_dout` in 48: queue head, combinational.
- `render_q_pop_front` out 1: one-cycle pop.
- `pixel_addr` out ADDR_W: image memory read address.
- `pixel_din` in 24: image memory data, valid 1 cycle after `pixel_addr`.
- `lb_rd_addr` in 10: scan-out read address into the display bank.
- `lb_rd_data` out 24: registered, 1-cycle read latency.
- `line_done` out 1: one-cycle pulse when the write bank is complete.
- `overrun` out 1: sticky. Set when `line_req` arrives while busy. Cleared by `frame_start`.

## Operation
- Entry format:
  - [47:40] sprite_id
  - [39:30] x
  - [29:20] y
  - [19:0] ignored
- Sprite base address = sprite_id × SPRITE_W × SPRITE_H, truncated to ADDR_W.
- States: IDLE, LOAD, CLEAR, SCAN, FETCH, DRAIN.
- **IDLE**
  - A pending `frame_start` goes to LOAD.
  - `line_req` swaps banks, latches `line_y`, and goes to CLEAR.
  - If both are present, LOAD runs first and the line request stays pending.
- **LOAD**
  - Table count reset to 0.
  - Each cycle with `render_q_lw`=0 and count<MAX_SPRITES: capture `render_q_dout`, pulse pop, increment count.
  - Exit to IDLE when `render_q_lw`=1 or the table is full. Surplus entries stay queued.
- **CLEAR**: write BG_COLOR to write-bank addresses 0..LINE_W-1, one per cycle.
- **SCAN**
  - Step index i from 0 to count-1, one cycle per entry.
  - An entry hits when y ≤ line_y < y+SPRITE_H; compare at 11 bits so y+SPRITE_H cannot wrap.
  - On a hit, go to FETCH. After the last entry, go to DRAIN.
- **FETCH**
  - Issue SPRITE_W reads: `pixel_addr` = base + (line_y−y)×SPRITE_W + col, col = 0..SPRITE_W−1.
  - A write pipeline delays col by 1 and writes `pixel_din` to address x+col.
  - A write is suppressed when x+col ≥ LINE_W (11-bit sum; no wrap to the left edge).
  - Return to SCAN at i+1.
- **DRAIN**: flush the last write, pulse `line_done`, go to IDLE.
- `frame_start` outside IDLE latches a pending flag. At most one is held; duplicates merge.
- `line_req` outside IDLE:
  - sets `overrun`;
  - aborts the current line without `line_done`;
  - swaps banks and restarts at CLEAR with the new `line_y`.
- Reset values:
  - `render_q_pop_front`=0, `line_done`=0, `overrun`=0
  - `pixel_addr`=0, `lb_rd_data`=0
  - state IDLE, table count 0
  - display bank 0, write bank 1
  - pending flags 0
- Line-buffer RAM contents are not reset.

## Timing
- Pop to next head: one cycle. Back-to-back pops are allowed every cycle.
- LOAD latency for N entries: N cycles, plus 1 cycle to exit.
- Line latency from `line_req` to `line_done`: 1 + LINE_W + count + hits×(SPRITE_W+1) + 1 cycles.
  - Worst case at defaults: 1 + 640 + 25 + 825 + 1 = 1492.
  - This is less than the 1600 clk50 cycles per 800-pixel line.
- Bank swap occurs on the `line_req` cycle. `lb_rd_data` follows `lb_rd_addr` by exactly 1 cycle.
- Simultaneous write and read never hit the same bank.

## Configuration
- `SPRITE_TRANSPARENCY_EN` defined:
  - A fetched pixel equal to 24'hFF00FF is not written.
  - Underlying BG_COLOR or earlier sprites show through.
- `SPRITE_TRANSPARENCY_EN` undefined: every fetched pixel in range is written, including 24'hFF00FF.

## Test plan
- Reset mid-FETCH:
  - Required: all outputs return to their reset values next cycle.
  - Then `frame_start` with an empty queue → count 0, no pops.
- Queue holds 3 entries (id 1, x 10, y 5), (id 2, x 20, y 100), (id 0, x 0, y 0), followed by `frame_start`:
  - Required: exactly 3 pop pulses on consecutive cycles.
  - `line_req` with `line_y`=6 → bank has sprite 1 row 1 at x 10..41 and sprite 0 row 6 at x 0..31.
  - Sprite 0 wins at x 10..31. BG elsewhere. `line_done` at the computed cycle.
- 30 entries queued, then `frame_start`:
  - Required: 25 pops, 5 entries left, `render_q_lw` stays 0.
- Entry x=630, `line_req`:
  - Required: pixels written to 630..639 only.
  - No writes to addresses 0..21.
- Second `line_req` issued 100 cycles after the first:
  - Required: `overrun`=1, no `line_done` for the first line.
  - Second line completes. `overrun` clears on the next `frame_start`.
- Transparency, with the macro defined:
  - Sprite whose row is 24'hFF00FF at columns 0..15 over an earlier opaque sprite.
  - Required: the earlier sprite's pixels remain at those columns.
  - Macro undefined: 24'hFF00FF is written.

Source files
------------

// File: rtl/sprite_line_renderer.sv
// Sprite table loader and per-scanline compositor into a double-buffered line RAM.
// Optional: SPRITE_TRANSPARENCY_EN skips fetched pixels equal to 24'hFF00FF.
module sprite_line_renderer #(
  parameter int          LINE_W      = 640,
  parameter int          SPRITE_W    = 32,
  parameter int          SPRITE_H    = 32,
  parameter int          MAX_SPRITES = 25,
  parameter int          ADDR_W      = 20,
  parameter logic [23:0] BG_COLOR    = 24'h000000
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              line_req,
  input  logic [9:0]        line_y,
  input  logic              render_q_lw,
  input  logic [47:0]       render_q_dout,
  output logic              render_q_pop_front,
  output logic [ADDR_W-1:0] pixel_addr,
  input  logic [23:0]       pixel_din,
  input  logic [9:0]        lb_rd_addr,
  output logic [23:0]       lb_rd_data,
  output logic              line_done,
  output logic              overrun
);

  localparam int CW  = $clog2(MAX_SPRITES + 1);
  localparam int SCW = $clog2(SPRITE_W + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, CLEAR, SCAN, FETCH, DRAIN
  } state_t;

  state_t state, nstate;

  logic [7:0]  t_id [MAX_SPRITES];
  logic [9:0]  t_x  [MAX_SPRITES];
  logic [9:0]  t_y  [MAX_SPRITES];
  logic [23:0] lb   [2048];

  logic [CW-1:0]     cnt, idx;
  logic [9:0]        clr_addr, ly, pend_y, sx;
  logic [SCW-1:0]    col, wr_col;
  logic              frame_pend, line_pend, disp_bank, wr_en;
  logic              busy, abort, hit, last, go_load, start_line;
  logic              opaque, wr_ok, clr_we;
  logic [10:0]       e_y, wr_x;
  logic [9:0]        row;
  logic [ADDR_W-1:0] base_row;
  logic              unused_q;

  assign unused_q   = ^render_q_dout[19:0];
  assign busy       = state inside {CLEAR, SCAN, FETCH, DRAIN};
  assign abort      = line_req && busy;
  assign go_load    = (state == IDLE) && (frame_pend || frame_start);
  assign start_line = (state == IDLE) && !(frame_pend || frame_start)
                      && (line_pend || line_req);

  // 11-bit compare so y + SPRITE_H never wraps
  assign e_y  = {1'b0, t_y[idx]};
  assign hit  = (e_y <= {1'b0, ly}) && ({1'b0, ly} < e_y + 11'(SPRITE_H));
  assign last = (idx + CW'(1)) == cnt;
  assign row  = ly - t_y[idx];
  assign base_row = ADDR_W'(32'(t_id[idx]) * 32'(SPRITE_W * SPRITE_H)
                            + 32'(row) * 32'(SPRITE_W));

  assign wr_x = {1'b0, sx} + 11'(wr_col);

`ifdef SPRITE_TRANSPARENCY_EN
  assign opaque = (pixel_din != 24'hFF00FF);
`else
  assign opaque = 1'b1;
`endif

  assign wr_ok = wr_en && (wr_x < 11'(LINE_W)) && opaque && !abort;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (frame_pend || frame_start)  nstate = LOAD;
        else if (line_pend || line_req) nstate = CLEAR;
      end
      LOAD:
        if (render_q_lw || cnt == CW'(MAX_SPRITES)) nstate = IDLE;
      CLEAR:
        if (clr_addr == 10'(LINE_W - 1))
          nstate = (cnt == '0) ? DRAIN : SCAN;
      SCAN: begin
        if (hit)       nstate = FETCH;
        else if (last) nstate = DRAIN;
      end
      FETCH:
        if (col == SCW'(SPRITE_W)) nstate = last ? DRAIN : SCAN;
      DRAIN: nstate = IDLE;
      default: nstate = IDLE;
    endcase
    if (abort) nstate = CLEAR;
  end

  always_comb begin
    render_q_pop_front = 1'b0;
    clr_we             = 1'b0;
    unique case (state)
      LOAD:  render_q_pop_front = !render_q_lw && (cnt < CW'(MAX_SPRITES));
      CLEAR: clr_we = !abort;
      default: ;
    endcase
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      idx        <= '0;
      clr_addr   <= '0;
      ly         <= '0;
      pend_y     <= '0;
      sx         <= '0;
      col        <= '0;
      wr_col     <= '0;
      frame_pend <= 1'b0;
      line_pend  <= 1'b0;
      disp_bank  <= 1'b0;
      wr_en      <= 1'b0;
      pixel_addr <= '0;
      line_done  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      line_done <= (state == DRAIN) && !abort;
      wr_en     <= (state == FETCH) && (col < SCW'(SPRITE_W)) && !abort;
      wr_col    <= col;

      if (abort)            overrun <= 1'b1;
      else if (frame_start) overrun <= 1'b0;

      if (state == IDLE)    frame_pend <= 1'b0;
      else if (frame_start) frame_pend <= 1'b1;

      if (go_load)                 cnt <= '0;
      else if (render_q_pop_front) cnt <= cnt + CW'(1);

      // a line request meeting a table load waits behind it
      if ((go_load || state == LOAD) && line_req) begin
        line_pend <= 1'b1;
        pend_y    <= line_y;
      end

      if (start_line || abort) begin
        disp_bank <= ~disp_bank;
        ly        <= line_req ? line_y : pend_y;
        line_pend <= 1'b0;
        clr_addr  <= '0;
        idx       <= '0;
      end else begin
        unique case (state)
          CLEAR: clr_addr <= clr_addr + 10'd1;
          SCAN: begin
            if (hit) begin
              pixel_addr <= base_row;
              sx         <= t_x[idx];
              col        <= '0;
            end else begin
              idx <= idx + CW'(1);
            end
          end
          FETCH: begin
            col <= col + SCW'(1);
            if (col < SCW'(SPRITE_W - 1))
              pixel_addr <= pixel_addr + ADDR_W'(1);
            if (col == SCW'(SPRITE_W))
              idx <= idx + CW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (render_q_pop_front) begin
      t_id[cnt] <= render_q_dout[47:40];
      t_x[cnt]  <= render_q_dout[39:30];
      t_y[cnt]  <= render_q_dout[29:20];
    end
  end

  always_ff @(posedge clk50) begin
    if (clr_we)
      lb[{~disp_bank, clr_addr}] <= BG_COLOR;
    else if (wr_ok)
      lb[{~disp_bank, wr_x[9:0]}] <= pixel_din;
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) lb_rd_data <= '0;
    else       lb_rd_data <= lb[{disp_bank, lb_rd_addr}];
  end

endmodule
